// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core and its host-side sequencer:
// default widths, the controller state encoding and the watchdog margin.
package fir_pkg;

  localparam int FIR_DATA_W   = 32;
  localparam int FIR_COEF_W   = 32;
  localparam int FIR_MAX_TAPS = 64;
  localparam int FIR_TAPS_W   = 6;

  // Extra cycles beyond the tap count before a missing core result is flagged.
  localparam int WD_MARGIN = 16;

  typedef enum logic [2:0] {
    FC_IDLE  = 3'd0,
    FC_LOAD  = 3'd1,
    FC_FEED  = 3'd2,
    FC_START = 3'd3,
    FC_WAIT  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/fir_ctrl_fifo.sv
// Result FIFO for fir_ctrl: registered pointers on a power-of-2 depth,
// occupancy counter, head data forced to zero while empty.
module fir_ctrl_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// Host-side sequencer for fir_core: loads coefficients, feeds one sample at a
// time, and buffers each one-cycle core result in a backpressured FIFO.
//
// Handshakes: a transfer happens on any rising clk edge where valid && ready
// are both high; valid/data hold until that edge, ready never depends on the
// same interface's valid (coef, s, m and core_in all follow this rule).
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_W     = FIR_DATA_W,
  parameter int COEF_W     = FIR_COEF_W,
  parameter int MAX_TAPS   = FIR_MAX_TAPS,
  parameter int TAPS_W     = FIR_TAPS_W,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAPS_W-1:0] cfg_taps,
  input  logic              coef_load,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [TAPS_W-1:0] core_taps,
  output logic              core_coef_wr,
  output logic [TAPS_W-1:0] core_coef_wr_addr,
  output logic [COEF_W-1:0] core_coef_wr_data,
  output logic              core_in_valid,
  output logic [DATA_W-1:0] core_in_sample,
  input  logic              core_in_ready,
  output logic              core_start_proc,
  input  logic              core_out_valid,
  input  logic [DATA_W-1:0] core_out_sample,
  output logic              coef_loaded,
  output logic              busy,
  output logic              err_cfg,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [2:0]        dbg_state
);

  localparam int WD_W = TAPS_W + 5;

  fc_state_e         state;
  logic [TAPS_W-1:0] taps_q;
  logic [TAPS_W-1:0] idx_q;
  logic [DATA_W-1:0] sample_q;
  logic [WD_W-1:0]   wd_q;
  logic [WD_W-1:0]   wd_limit;
  logic              loaded_q;
  logic              err_cfg_q;
  logic              err_to_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_space;
  logic [FIFO_AW:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  assign wd_limit = WD_W'(taps_q) + WD_W'(WD_MARGIN);

  // Core-side strobes decode straight from the registered state.
  assign busy              = (state != FC_IDLE);
  assign coef_ready        = (state == FC_LOAD);
  assign core_coef_wr      = (state == FC_LOAD) && coef_valid;
  assign core_coef_wr_addr = (state == FC_LOAD) ? idx_q : '0;
  assign core_coef_wr_data = core_coef_wr ? coef_data : '0;
  assign core_in_valid     = (state == FC_FEED);
  assign core_in_sample    = sample_q;
  assign core_start_proc   = (state == FC_START);
  assign core_taps         = taps_q;
  assign coef_loaded       = loaded_q;
  assign err_cfg           = err_cfg_q;
  assign err_timeout       = err_to_q;
  assign dbg_state         = state;

  // A sample is only admitted when its result is sure to fit in the FIFO;
  // a coefficient load in the same cycle takes precedence.
  assign fifo_space = (fifo_count < (FIFO_AW+1)'(FIFO_DEPTH));
  assign s_ready    = (state == FC_IDLE) && loaded_q && fifo_space && !coef_load;

  assign fifo_push = (state == FC_WAIT) && core_out_valid && !fifo_full;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_head;
  assign fifo_pop  = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FC_IDLE;
      taps_q    <= '0;
      idx_q     <= '0;
      sample_q  <= '0;
      wd_q      <= '0;
      loaded_q  <= 1'b0;
      err_cfg_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      // Clear first so a set event later in this block wins.
      if (err_clr) begin
        err_cfg_q <= 1'b0;
        err_to_q  <= 1'b0;
      end
      case (state)
        FC_IDLE: begin
          if (coef_load) begin
            if (cfg_taps == '0) begin
              err_cfg_q <= 1'b1;
            end else begin
              taps_q   <= cfg_taps;
              idx_q    <= '0;
              loaded_q <= 1'b0;
              state    <= FC_LOAD;
            end
          end else if (s_valid && s_ready) begin
            sample_q <= s_data;
            state    <= FC_FEED;
          end
        end
        FC_LOAD: begin
          if (coef_valid) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == taps_q - 1'b1) begin
              loaded_q <= 1'b1;
              state    <= FC_IDLE;
            end
          end
        end
        FC_FEED: begin
          if (core_in_ready) state <= FC_START;
        end
        FC_START: begin
          // wd_q counts cycles since the START cycle, START itself being 1.
          wd_q  <= WD_W'(1);
          state <= FC_WAIT;
        end
        FC_WAIT: begin
          wd_q <= wd_q + 1'b1;
          if (core_out_valid) begin
            state <= FC_IDLE;
          end else if (wd_q == wd_limit - 1'b1) begin
            err_to_q <= 1'b1;
            state    <= FC_IDLE;
          end
        end
        default: state <= FC_IDLE;
      endcase
    end
  end

  fir_ctrl_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (core_out_sample),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencer that drives the `fir_core` control, coefficient and streaming ports from the host side. It loads a coefficient set over a valid/ready stream and writes it into the core. It then feeds samples one at a time: present sample, pulse `start_proc`, wait for `out_valid`. Each result is captured into an output FIFO with valid/ready backpressure, so the core's un-throttled one-cycle `out_valid` pulse is never lost.

## Interface
Parameters:
- `DATA_W`, 32, sample/result width (matches core)
- `COEF_W`, 32, coefficient width
- `MAX_TAPS`, 64, core tap capacity
- `TAPS_W`, 6, tap index width
- `FIFO_DEPTH`, 8, result FIFO entries (power of 2)
- `FIFO_AW`, 3, log2(FIFO_DEPTH)

Ports:
- Clocking: one clock, `clk`. Reset is `rst_n`: asynchronous, active-low.
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `cfg_taps` in TAPS_W: tap count, latched at `coef_load`.
- `coef_load` in 1: pulse that starts a coefficient load.
- `coef_valid` in 1: coefficient stream valid.
- `coef_data` in COEF_W: coefficient, index 0 first.
- `coef_ready` out 1: coefficient accepted.
- `s_valid` in 1: input sample valid.
- `s_data` in DATA_W: input sample.
- `s_ready` out 1: sample accepted.
- `m_valid` out 1: result available (FIFO not empty).
- `m_data` out DATA_W: result at FIFO head.
- `m_ready` in 1: result consumed.
- `core_taps` out TAPS_W: latched tap count.
- `core_coef_wr` out 1: coefficient write strobe.
- `core_coef_wr_addr` out TAPS_W: write address.
- `core_coef_wr_data` out COEF_W: write data.
- `core_in_valid` out 1: sample valid to core.
- `core_in_sample` out DATA_W: held sample.
- `core_in_ready` in 1: core accepts sample.
- `core_start_proc` out 1: start MAC, one-cycle pulse.
- `core_out_valid` in 1: core result pulse.
- `core_out_sample` in DATA_W: core result.
- `coef_loaded` out 1: valid coefficient set present.
- `busy` out 1: state is not IDLE.
- `err_cfg` out 1: sticky; load attempted with `cfg_taps==0`.
- `err_timeout` out 1: sticky; core result missing.
- `err_clr` in 1: clears both sticky errors.

## Operation
- FSM states are IDLE, LOAD, FEED, START, WAIT. Core-side outputs decode from registered state and holding registers.
- **IDLE**
  - `coef_load` with `cfg_taps!=0`: latch taps and go to LOAD. Clear `coef_loaded` and the index counter.
  - `coef_load` with `cfg_taps==0`: set `err_cfg`, stay in IDLE, make no writes.
  - Otherwise, if `coef_loaded && fifo_count<FIFO_DEPTH`: drive `s_ready=1`. On `s_valid`, latch `s_data` and go to FEED.
  - `coef_load` has priority over a sample in the same cycle.
- **LOAD**
  - `coef_ready=1`. Each `coef_valid` cycle drives `core_coef_wr=1`, addr=index, data=`coef_data` combinationally, then increments the index.
  - The write at index `taps-1` sets `coef_loaded` and returns to IDLE.
  - `s_ready=0` throughout.
- **FEED**: `core_in_valid=1` with the held sample. Stay until `core_in_ready`, then go to START.
- **START**: `core_start_proc=1` for exactly one cycle. This is the cycle after the core shifted the sample in, so the core's snapshot includes it. Clear the watchdog, go to WAIT.
- **WAIT**
  - Watchdog increments each cycle.
  - `core_out_valid`: push `core_out_sample` into the FIFO and go to IDLE.
  - Watchdog reaching `taps+WD_MARGIN` (16): set `err_timeout`, push nothing, go to IDLE.
- FIFO space is guaranteed at push: only one sample is in flight, and admission checked `count<FIFO_DEPTH`.
- Push and pop in the same cycle leave the count unchanged.
- Pop happens on `m_valid && m_ready`.
- `err_clr` clears the sticky flags. A set event in the same cycle wins.

## Timing
- Reset values: FSM=IDLE.
  - All handshake/strobe outputs are 0: `coef_ready`, `s_ready`, `m_valid`, `core_coef_wr`, `core_in_valid`, `core_start_proc`, `busy`, `coef_loaded`, `err_cfg`, `err_timeout`.
  - All data outputs and `core_taps` are 0. FIFO is empty.
- Reset asserted mid-operation aborts immediately. Buffered results are discarded and `coef_loaded` drops, so a reload is required.
- Coefficient load takes `taps` accepted beats. `busy` is high from the cycle after `coef_load` until the last beat.
- Per-sample minimum is 3 cycles (IDLE, FEED, START) plus core latency in WAIT.
- The result appears on `m_valid` the cycle after the `core_out_valid` pulse.
- A `core_out_valid` pulse outside WAIT is ignored.

## Structure
- Shared package `fir_pkg` holds:
  - FSM state encoding (`FC_IDLE`..`FC_WAIT`)
  - `WD_MARGIN=16`
  - default widths shared with `fir_core`
- Sub-module `fir_ctrl_fifo`: synchronous FIFO with parameters `W`, `DEPTH`, `AW`. Ports: push, pop, count, full, empty, head data. Registered pointers, wrap-around on power-of-2 depth.

## Test plan
- Load: `cfg_taps=4`, coef stream 1,2,3,4 -> four `core_coef_wr` pulses with addr 0..3 and data 1..4. `coef_loaded=1` one cycle after the last beat.
- Impulse: with a behavioural core model, samples 1,0,0,0 -> `m_data` 1,2,3,4 in order. Exactly one `core_start_proc` per sample.
- Backpressure: `m_ready=0`, send 10 samples -> `s_ready` stays 0 after the 8th result is buffered. Raise `m_ready` -> all 10 results drain, none lost or duplicated.
- Timeout: stub core never pulses `out_valid`, `taps=4` -> `err_timeout=1` 20 cycles after START, FSM back in IDLE. `err_clr` -> flag 0.
- Config error: `coef_load` with `cfg_taps=0` -> `err_cfg=1`, no `core_coef_wr`, `coef_loaded` unchanged.
- Reset in WAIT with 3 results buffered -> all outputs 0 asynchronously, `m_valid=0`, `coef_loaded=0`, `s_ready=0` until reload.
